// File: rtl/pipe_ctrl.sv
// Pipeline stall/flush controller: merges ID and EX hold requests and the flush
// request into a per-stage stall vector, sequences multi-cycle EX ops and counts stalled cycles.
module pipe_ctrl #(
    parameter int unsigned MC_CYCLES = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        pipe_ctrl_stallreq_id_i,
    input  logic        pipe_ctrl_mc_req_i,
    input  logic        pipe_ctrl_flush_req_i,
    output logic [5:0]  pipe_ctrl_stall_o,
    output logic        pipe_ctrl_flush_o,
    output logic        pipe_ctrl_mc_done_o,
    output logic        pipe_ctrl_busy_o,
    output logic [31:0] pipe_ctrl_stall_cnt_o
);

    localparam int unsigned CW = (MC_CYCLES > 1) ? $clog2(MC_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_START = CW'(MC_CYCLES - 2);
    localparam logic [5:0] STALL_ID   = 6'b000111;
    localparam logic [5:0] STALL_EX   = 6'b001111;
    localparam logic [5:0] STALL_NONE = 6'b000000;

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        DONE
    } state_t;

    state_t        state_q;
    logic [CW-1:0] cnt_q;
    logic [31:0]   stall_cnt_q;
    logic [31:0]   stall_cnt_d;
    logic          ex_stall;

    // The IDLE cycle that accepts the request already counts as the first stall cycle.
    always_comb begin
        ex_stall            = ((state_q == IDLE) && pipe_ctrl_mc_req_i) || (state_q == BUSY);
        pipe_ctrl_stall_o   = STALL_NONE;
        pipe_ctrl_flush_o   = 1'b0;
        pipe_ctrl_mc_done_o = 1'b0;
        pipe_ctrl_busy_o    = 1'b0;
        if (!rst) begin
            pipe_ctrl_busy_o  = (state_q != IDLE);
            pipe_ctrl_flush_o = pipe_ctrl_flush_req_i;
            if (!pipe_ctrl_flush_req_i) begin
                pipe_ctrl_mc_done_o = (state_q == DONE);
                if (ex_stall) begin
                    pipe_ctrl_stall_o = STALL_EX;
                end else if (pipe_ctrl_stallreq_id_i) begin
                    pipe_ctrl_stall_o = STALL_ID;
                end
            end
        end
    end

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if ((pipe_ctrl_stall_o != STALL_NONE) && (stall_cnt_q != '1)) begin
            stall_cnt_d = stall_cnt_q + 32'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            stall_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
            if (pipe_ctrl_flush_req_i) begin
                state_q <= IDLE;
                cnt_q   <= '0;
            end else begin
                case (state_q)
                    IDLE: begin
                        if (pipe_ctrl_mc_req_i) begin
                            state_q <= BUSY;
                            cnt_q   <= CNT_START;
                        end
                    end
                    BUSY: begin
                        if (cnt_q == '0) begin
                            state_q <= DONE;
                        end else begin
                            cnt_q <= cnt_q - CW'(1);
                        end
                    end
                    DONE:    state_q <= IDLE;
                    default: state_q <= IDLE;
                endcase
            end
        end
    end

    assign pipe_ctrl_stall_cnt_o = stall_cnt_q;

endmodule

// File: tb/tb_pipe_ctrl.sv
// Randomized and directed bench for pipe_ctrl; a cycle-level reference model
// pushes expected outputs into a queue that a negedge monitor pops and compares.
module tb_pipe_ctrl;

    localparam int unsigned MC = 4;

    typedef struct packed {
        logic [5:0]  stall;
        logic        flush;
        logic        done;
        logic        busy;
        logic [31:0] cnt;
    } exp_t;

    logic        clk;
    logic        rst;
    logic        id_req;
    logic        mc_req;
    logic        fl_req;
    logic [5:0]  stall;
    logic        flush;
    logic        done;
    logic        busy;
    logic [31:0] scnt;

    exp_t exp_q[$];
    int   checks;
    int   errors;

    // Reference model: stall cycles still owed by the current op, and a pending done cycle.
    int          m_rem;
    bit          m_done;
    logic [31:0] m_cnt;

    pipe_ctrl #(.MC_CYCLES(MC)) dut (
        .clk                     (clk),
        .rst                     (rst),
        .pipe_ctrl_stallreq_id_i (id_req),
        .pipe_ctrl_mc_req_i      (mc_req),
        .pipe_ctrl_flush_req_i   (fl_req),
        .pipe_ctrl_stall_o       (stall),
        .pipe_ctrl_flush_o       (flush),
        .pipe_ctrl_mc_done_o     (done),
        .pipe_ctrl_busy_o        (busy),
        .pipe_ctrl_stall_cnt_o   (scnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, expv, $time);
        end
    endtask

    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("stall_o",     32'(stall), 32'(e.stall));
                check("flush_o",     32'(flush), 32'(e.flush));
                check("mc_done_o",   32'(done),  32'(e.done));
                check("busy_o",      32'(busy),  32'(e.busy));
                check("stall_cnt_o", scnt,       e.cnt);
            end
        end
    end

    // Model evaluation for the current cycle, then advance to the next cycle.
    task automatic model_step(input bit r, input bit id, input bit mc, input bit fl);
        exp_t e;
        bit   ex;
        e     = '0;
        e.cnt = m_cnt;
        if (r) begin
            m_rem  = 0;
            m_done = 0;
            m_cnt  = '0;
        end else begin
            e.busy  = (m_rem > 0) || m_done;
            e.flush = fl;
            if (fl) begin
                m_rem  = 0;
                m_done = 0;
            end else begin
                ex = 0;
                if (m_done) begin
                    e.done = 1;
                    m_done = 0;
                end else if (m_rem > 0) begin
                    ex = 1;
                    m_rem--;
                    if (m_rem == 0) m_done = 1;
                end else if (mc) begin
                    ex    = 1;
                    m_rem = MC - 1;
                end
                if (ex)      e.stall = 6'b001111;
                else if (id) e.stall = 6'b000111;
                if (e.stall != 0 && m_cnt != 32'hFFFF_FFFF) m_cnt = m_cnt + 1;
            end
        end
        exp_q.push_back(e);
    endtask

    task automatic cyc(input bit r, input bit id, input bit mc, input bit fl);
        @(posedge clk);
        #1;
        rst    = r;
        id_req = id;
        mc_req = mc;
        fl_req = fl;
        model_step(r, id, mc, fl);
    endtask

    task automatic preload_cnt();
        @(posedge clk);
        #1;
        rst    = 0;
        id_req = 0;
        mc_req = 0;
        fl_req = 0;
        force dut.stall_cnt_q = 32'hFFFF_FFFE;
        #1;
        release dut.stall_cnt_q;
        m_cnt = 32'hFFFF_FFFE;
        model_step(0, 0, 0, 0);
    endtask

    initial begin
        checks = 0;
        errors = 0;
        m_rem  = 0;
        m_done = 0;
        m_cnt  = '0;
        rst    = 1;
        id_req = 1;
        mc_req = 1;
        fl_req = 1;
        @(posedge clk);

        repeat (2) cyc(1, 1, 1, 1);
        // Single-cycle load-use hazard
        cyc(0, 1, 0, 0);
        repeat (2) cyc(0, 0, 0, 0);
        // Multi-cycle op held through its done cycle
        repeat (5) cyc(0, 0, 1, 0);
        repeat (2) cyc(0, 0, 0, 0);
        // Flush abort in BUSY
        repeat (2) cyc(0, 0, 1, 0);
        cyc(0, 0, 1, 1);
        repeat (3) cyc(0, 0, 0, 0);
        // ID overlap during BUSY and DONE, then back-to-back op
        cyc(0, 0, 1, 0);
        repeat (4) cyc(0, 1, 1, 0);
        repeat (5) cyc(0, 0, 1, 0);
        repeat (2) cyc(0, 0, 0, 0);
        // Flush in DONE
        repeat (4) cyc(0, 0, 1, 0);
        cyc(0, 0, 1, 1);
        cyc(0, 0, 0, 0);
        // Counter saturation, then reset mid-op
        preload_cnt();
        repeat (3) cyc(0, 1, 0, 0);
        repeat (2) cyc(0, 0, 1, 0);
        cyc(1, 0, 1, 0);
        repeat (2) cyc(0, 0, 0, 0);

        for (int i = 0; i < 400; i++) begin
            cyc(($urandom_range(39) == 0), ($urandom_range(2) == 0),
                ($urandom_range(2) != 0), ($urandom_range(14) == 0));
        end
        cyc(0, 0, 0, 0);

        for (int k = 0; k < 4 && exp_q.size() > 0; k++) @(negedge clk);
        #1;
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/pipe_ctrl.md
# pipe_ctrl

Pipeline stall and flush controller for the five-stage MIPS core. It gathers hold requests from ID (load-use hazard) and EX (multi-cycle arithmetic), and an exception flush request. From these it drives the per-stage stall vector consumed by the PC, IF/ID, ID/EX, EX/MEM and MEM/WB pipeline registers. It also sequences multi-cycle EX operations with an internal FSM and counter, and keeps a saturating stall-cycle performance counter.

## Interface
Parameters:
- MC_CYCLES, 4, stall cycles per multi-cycle EX operation; legal range 2..64.

Ports:
- clk  input  1  clock; all state updates on posedge.
- rst  input  1  reset; synchronous, active-high.
- pipe_ctrl_stallreq_id_i  input  1  ID load-use hazard request; combinational, same-cycle.
- pipe_ctrl_mc_req_i  input  1  EX holds a multi-cycle op; high while that instruction sits in EX.
- pipe_ctrl_flush_req_i  input  1  exception or flush request from MEM.
- pipe_ctrl_stall_o  output  6  per-stage hold: [0] PC, [1] IF/ID, [2] ID/EX, [3] EX/MEM, [4] MEM/WB, [5] reserved (always 0).
- pipe_ctrl_flush_o  output  1  clear all pipeline registers this cycle.
- pipe_ctrl_mc_done_o  output  1  one-cycle pulse: EX result valid, and the instruction leaves EX at the end of this cycle.
- pipe_ctrl_busy_o  output  1  FSM is not IDLE.
- pipe_ctrl_stall_cnt_o  output  32  count of cycles with stall_o != 0; saturating.

## Operation
- Stall vector semantics: a register whose bit is 1 holds its value. A bubble enters stage i+1 when stall[i]=1 and stall[i+1]=0.
- Stall patterns:
  - ID stall: 6'b000111.
  - EX stall: 6'b001111.
  - None: 6'b000000.
- Priority: flush > EX stall > ID stall.
- Flush behaviour:
  - flush_o = flush_req_i and stall_o = 0, in the same cycle (combinational).
  - On the next edge the FSM returns to IDLE and the counter is cleared.
  - mc_done_o is not pulsed for an aborted operation.
- FSM states: IDLE, BUSY, DONE. The state and the down-counter cnt (width $clog2(MC_CYCLES)) are registered.
  - IDLE: if mc_req_i and not flush, EX stall is asserted this cycle, cnt <= MC_CYCLES-2, next state is BUSY. Otherwise stay in IDLE.
  - BUSY: EX stall is asserted. If cnt==0, next state is DONE; otherwise cnt <= cnt-1.
  - DONE: mc_done_o=1 and no EX stall. An ID stall is still honoured if requested. Next state is IDLE unconditionally. mc_req_i being high in DONE belongs to the finishing instruction and must not restart the FSM.
- busy_o = (state != IDLE).
- stall_cnt: increments on every edge where stall_o != 0 and rst=0. It holds at 32'hFFFF_FFFF.
- Outputs stall_o, flush_o and mc_done_o are combinational from the registered state and the current inputs. No input-to-output path depends on cnt.

## Timing
- Reset (rst=1 at an edge): state=IDLE, cnt=0, stall_cnt=0.
- While rst=1, all outputs are forced low: stall_o=0, flush_o=0, mc_done_o=0, busy_o=0.
- Reset mid-operation: at the next edge the FSM is in IDLE. No done pulse is issued and there is no residual stall.
- Multi-cycle latency, with mc_req_i first seen in IDLE at cycle T:
  - stall_o=001111 in cycles T .. T+MC_CYCLES-1 (exactly MC_CYCLES cycles).
  - mc_done_o=1 in cycle T+MC_CYCLES.
  - IDLE again at T+MC_CYCLES+1.
- MC_CYCLES=2: IDLE (stall), one BUSY (stall), then DONE.
- Back-to-back multi-cycle ops: a new mc_req_i in the IDLE cycle after DONE starts a new sequence immediately. There is zero gap cycles between done and the next stall.
- Flush during BUSY or DONE: flush_o=1 and stall_o=0 that cycle. IDLE follows on the next edge.
- ID and EX requests together: EX pattern wins. The ID request is re-evaluated every cycle by the requester.

## Test plan
- Reset: hold rst=1 for 2 cycles with all requests high -> all outputs 0 and stall_cnt_o=0. Release rst -> state transitions start at the first edge.
- ID hazard: stallreq_id_i=1 for 1 cycle (MC_CYCLES=4) -> stall_o=6'b000111 that cycle only, stall_cnt_o=1, busy_o never 1.
- Multi-cycle op: mc_req_i=1 from T through T+4 -> stall_o=001111 for T..T+3, mc_done_o=1 only at T+4, busy_o=1 for T+1..T+4, stall_cnt_o=4.
- Flush abort: start an op at T, flush_req_i=1 at T+2 -> flush_o=1 and stall_o=0 at T+2, busy_o=0 at T+3, no mc_done_o pulse ever.
- Overlap and back-to-back: stallreq_id_i=1 during BUSY -> stall_o stays 001111. stallreq_id_i=1 in DONE -> stall_o=000111 with mc_done_o=1. A new mc_req_i at T+5 -> stall_o=001111 at T+5.
- Saturation and mid-op reset: force stall_cnt to 32'hFFFF_FFFE, stall for 3 cycles -> counter reads FFFF_FFFF. Assert rst during BUSY -> IDLE next edge, no done pulse, stall_cnt_o=0.
